// File: rtl/conv2d_seq.sv
// Frame sequencer for the Conv2D3x3 streaming core: feeds NUM_CH frames from the
// input buffer into the core, collects the valid-convolution results, and clears the core between channels.
module conv2d_seq #(
  parameter int IMG_SIZE = 416,
  parameter int DATA_W   = 32,
  parameter int NUM_CH   = 3,
  parameter int ADDR_W   = 20,
  parameter int TIMEOUT  = 4096
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              start,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              conv_clr,
  output logic [DATA_W-1:0] conv_data_in,
  output logic              conv_valid_in,
  input  logic [DATA_W-1:0] conv_data_out,
  input  logic              conv_valid_out,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data
);

  localparam logic [ADDR_W-1:0] PIX       = ADDR_W'(IMG_SIZE * IMG_SIZE);
  localparam logic [ADDR_W-1:0] OPIX      = ADDR_W'((IMG_SIZE - 2) * (IMG_SIZE - 2));
  localparam logic [ADDR_W-1:0] PIX_LAST  = ADDR_W'(IMG_SIZE * IMG_SIZE - 1);
  localparam logic [ADDR_W-1:0] OPIX_LAST = ADDR_W'((IMG_SIZE - 2) * (IMG_SIZE - 2) - 1);
  localparam int                CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int                TMO_W     = $clog2(TIMEOUT + 1);
  localparam logic [CH_W-1:0]   LAST_CH   = CH_W'(NUM_CH - 1);
  localparam logic [TMO_W-1:0]  TMO_MAX   = TMO_W'(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_FEED, S_DRAIN, S_NEXT, S_DONE
  } state_t;

  state_t            state, state_nx;
  logic [CH_W-1:0]   ch;
  logic [ADDR_W-1:0] rd_ptr, wr_ptr;
  logic [TMO_W-1:0]  tmo;
  logic              ch_done;
  logic [ADDR_W-1:0] ch_ibase, ch_obase;
  logic              tmo_hit, collect;

  assign ch_ibase = ADDR_W'(ch) * PIX;
  assign ch_obase = ADDR_W'(ch) * OPIX;
  assign tmo_hit  = (tmo + 1'b1) == TMO_MAX;
  assign collect  = (state == S_FEED || state == S_DRAIN) && !ch_done;

  // The buffer already returns data one cycle after rd_en, so it lines up with the
  // registered valid; gating keeps the pixel bus at zero whenever nothing is issued.
  assign conv_data_in = conv_valid_in ? rd_data : '0;

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  // NOTE: every output of this block gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nx = state;
    busy     = (state != S_IDLE);
    done     = (state == S_DONE);
    conv_clr = (state == S_CLEAR);
    rd_en    = (state == S_FEED);
    rd_addr  = '0;
    if (state == S_FEED) rd_addr = ch_ibase + rd_ptr;

    if (abort) begin
      state_nx = S_IDLE;
    end else begin
      case (state)
        S_IDLE:  if (start) state_nx = S_CLEAR;
        S_CLEAR: state_nx = S_FEED;
        S_FEED:  if (rd_ptr == PIX_LAST) state_nx = S_DRAIN;
        S_DRAIN: begin
          if (ch_done)      state_nx = S_NEXT;
          else if (tmo_hit) state_nx = S_DONE;
        end
        S_NEXT:  state_nx = (ch == LAST_CH) ? S_DONE : S_CLEAR;
        S_DONE:  state_nx = S_IDLE;
        default: state_nx = S_IDLE;
      endcase
    end
  end

  // NOTE: registered state is updated with non-blocking assignments so every
  // read in this block sees the value from before the clock edge.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      ch            <= '0;
      rd_ptr        <= '0;
      wr_ptr        <= '0;
      tmo           <= '0;
      ch_done       <= 1'b0;
      err           <= 1'b0;
      conv_valid_in <= 1'b0;
      wr_en         <= 1'b0;
      wr_addr       <= '0;
      wr_data       <= '0;
    end else begin
      conv_valid_in <= rd_en && !abort;
      wr_en         <= 1'b0;

      if (!abort) begin
        case (state)
          S_IDLE: if (start) begin
            ch  <= '0;
            err <= 1'b0;
          end
          S_CLEAR: begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            tmo     <= '0;
            ch_done <= 1'b0;
          end
          S_FEED:  if (rd_ptr != PIX_LAST) rd_ptr <= rd_ptr + 1'b1;
          S_DRAIN: begin
            tmo <= tmo + 1'b1;
            if (!ch_done && tmo_hit) err <= 1'b1;
          end
          S_NEXT:  if (ch != LAST_CH) ch <= ch + 1'b1;
          default: ;
        endcase

        // Results past the last output of a channel are dropped rather than
        // spilling into the next channel's region.
        if (collect && conv_valid_out) begin
          wr_en   <= 1'b1;
          wr_addr <= ch_obase + wr_ptr;
          wr_data <= conv_data_out;
          if (wr_ptr == OPIX_LAST) ch_done <= 1'b1;
          else                     wr_ptr  <= wr_ptr + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_conv2d_seq.sv
// Directed bench for conv2d_seq: 4x4 frames, 2 channels, word = address input buffer,
// and a fixed-latency (5) behavioural core whose output pattern can be switched.
module tb_conv2d_seq;

  localparam int IMG = 4;
  localparam int DW  = 16;
  localparam int NCH = 2;
  localparam int AW  = 8;
  localparam int TMO = 32;

  logic          Clk = 1'b0;
  logic          Rst;
  logic          start, abort;
  logic          busy, done, err, rd_en, conv_clr, conv_valid_in, wr_en;
  logic [AW-1:0] rd_addr, wr_addr;
  logic [DW-1:0] rd_data, conv_data_in, conv_data_out, wr_data;
  logic          conv_valid_out;

  int n_checks = 0;
  int n_fail   = 0;

  bit mode_silent = 1'b0;
  bit mode_extra  = 1'b0;

  always #5 Clk = ~Clk;

  conv2d_seq #(
    .IMG_SIZE(IMG), .DATA_W(DW), .NUM_CH(NCH), .ADDR_W(AW), .TIMEOUT(TMO)
  ) dut (
    .Clk(Clk), .Rst(Rst), .start(start), .abort(abort),
    .busy(busy), .done(done), .err(err),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .conv_clr(conv_clr), .conv_data_in(conv_data_in), .conv_valid_in(conv_valid_in),
    .conv_data_out(conv_data_out), .conv_valid_out(conv_valid_out),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
  );

  // Input buffer: word value equals its address, one cycle read latency.
  always @(posedge Clk) if (rd_en) rd_data <= DW'(rd_addr);

  // Behavioural core: normal mode emits pixel values at window corners (2..3, 2..3);
  // extra mode emits pixel positions 10..15, i.e. six results per channel.
  logic [3:0]    pos;
  logic [4:0]    vsh;
  logic [DW-1:0] dsh [5];
  logic          qual;

  assign qual = mode_extra ? (pos >= 4'd10) : (pos[3:2] >= 2'd2 && pos[1:0] >= 2'd2);
  assign conv_valid_out = vsh[4] && !mode_silent;
  assign conv_data_out  = dsh[4];

  always @(posedge Clk) begin
    if (Rst || conv_clr) begin
      pos <= '0;
      vsh <= '0;
    end else begin
      if (conv_valid_in) pos <= pos + 4'd1;
      vsh <= {vsh[3:0], conv_valid_in && qual};
    end
    dsh[0] <= conv_data_in;
    for (int i = 1; i < 5; i++) dsh[i] <= dsh[i-1];
  end

  // Monitor sampled on the falling edge.
  int rd_q[$], vin_q[$], wa_q[$], wd_q[$];
  int clr_cnt = 0, done_cnt = 0, busy_cnt = 0, vin_bad = 0, clr_vin = 0;
  logic prev_rd_en = 1'b0;

  always @(negedge Clk) begin
    if (rd_en)         rd_q.push_back(int'(rd_addr));
    if (conv_valid_in) vin_q.push_back(int'(conv_data_in));
    if (wr_en) begin
      wa_q.push_back(int'(wr_addr));
      wd_q.push_back(int'(wr_data));
    end
    if (conv_clr) clr_cnt <= clr_cnt + 1;
    if (done)     done_cnt <= done_cnt + 1;
    if (busy)     busy_cnt <= busy_cnt + 1;
    if (conv_valid_in != prev_rd_en) vin_bad <= vin_bad + 1;
    if (conv_clr && conv_valid_in)   clr_vin <= clr_vin + 1;
    prev_rd_en <= rd_en;
  end

  int rd_base, vin_base, wr_base, clr_base, done_base, busy_base, vbad_base, cvin_base;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic snap();
    rd_base   = rd_q.size();
    vin_base  = vin_q.size();
    wr_base   = wa_q.size();
    clr_base  = clr_cnt;
    done_base = done_cnt;
    busy_base = busy_cnt;
    vbad_base = vin_bad;
    cvin_base = clr_vin;
  endtask

  task automatic wait_done(input string tag, input int budget);
    bit seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (done) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
    check({tag, "_done_seen"}, 32'(seen), 32'd1);
  endtask

  task automatic start_frame();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic check_frame(input string tag, input int exp_wd [8]);
    check({tag, "_rd_cnt"}, 32'(rd_q.size() - rd_base), 32'd32);
    for (int i = 0; i < 32 && rd_base + i < rd_q.size(); i++)
      check($sformatf("%s_rd%0d", tag, i), 32'(rd_q[rd_base + i]), 32'(i));
    check({tag, "_vin_cnt"}, 32'(vin_q.size() - vin_base), 32'd32);
    for (int i = 0; i < 32 && vin_base + i < vin_q.size(); i++)
      check($sformatf("%s_pix%0d", tag, i), 32'(vin_q[vin_base + i]), 32'(i));
    check({tag, "_wr_cnt"}, 32'(wa_q.size() - wr_base), 32'd8);
    for (int i = 0; i < 8 && wr_base + i < wa_q.size(); i++) begin
      check($sformatf("%s_wa%0d", tag, i), 32'(wa_q[wr_base + i]), 32'(i));
      check($sformatf("%s_wd%0d", tag, i), 32'(wd_q[wr_base + i]), 32'(exp_wd[i]));
    end
    check({tag, "_clr_cnt"},  32'(clr_cnt - clr_base),   32'd2);
    check({tag, "_done_cnt"}, 32'(done_cnt - done_base), 32'd1);
    check({tag, "_vin_align"}, 32'(vin_bad - vbad_base), 32'd0);
    check({tag, "_clr_vin"},  32'(clr_vin - cvin_base),  32'd0);
    check({tag, "_err"}, 32'(err), 32'd0);
  endtask

  initial begin
    Rst   = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    #1;
    check("rst_outs", {busy, done, err, rd_en, conv_clr, conv_valid_in, wr_en}, 32'd0);
    check("rst_buses", {rd_addr, wr_addr, wr_data}, 32'd0);
    tick();
    tick();
    Rst = 1'b0;
    tick();
    check("idle_busy", 32'(busy), 32'd0);

    // Single frame with cycle-accurate checks of the first few cycles.
    snap();
    start = 1'b1;
    tick();
    start = 1'b0;
    check("t1_clear", {busy, conv_clr, rd_en, conv_valid_in}, 32'b1100);
    tick();
    check("t2_feed", {rd_en, conv_clr, conv_valid_in}, 32'b100);
    check("t2_addr", 32'(rd_addr), 32'd0);
    tick();
    check("t3_vin", {rd_en, conv_valid_in}, 32'b11);
    check("t3_pix", 32'(conv_data_in), 32'd0);
    check("t3_addr", 32'(rd_addr), 32'd1);
    wait_done("norm", 300);
    check("norm_busy_at_done", 32'(busy), 32'd1);
    tick();
    check("norm_after_done", {busy, done}, 32'd0);
    check_frame("norm", '{10, 11, 14, 15, 26, 27, 30, 31});

    // Silent core: timeout after TMO drain cycles, no channel-1 reads.
    mode_silent = 1'b1;
    snap();
    start_frame();
    wait_done("tmo", 200);
    check("tmo_err_at_done", 32'(err), 32'd1);
    tick();
    check("tmo_busy_cycles", 32'(busy_cnt - busy_base), 32'(1 + 16 + TMO + 1));
    check("tmo_rd_cnt", 32'(rd_q.size() - rd_base), 32'd16);
    check("tmo_last_rd", 32'(rd_q[rd_q.size() - 1]), 32'd15);
    check("tmo_wr_cnt", 32'(wa_q.size() - wr_base), 32'd0);
    check("tmo_done_cnt", 32'(done_cnt - done_base), 32'd1);
    tick();
    check("tmo_err_sticky", 32'(err), 32'd1);
    mode_silent = 1'b0;

    // Abort at the 8th FEED cycle of channel 1.
    snap();
    start_frame();
    check("abort_err_cleared", 32'(err), 32'd0);
    begin
      bit hit = 1'b0;
      for (int i = 0; i < 200; i++) begin
        if (rd_en && rd_addr == AW'(23)) begin
          hit = 1'b1;
          break;
        end
        tick();
      end
      check("abort_reach_ch1", 32'(hit), 32'd1);
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_idle", {busy, rd_en, conv_valid_in, wr_en, done, err}, 32'd0);
    check("abort_ch0_writes", 32'(wa_q.size() - wr_base), 32'd4);
    snap();
    for (int i = 0; i < 20; i++) tick();
    check("abort_no_rd", 32'(rd_q.size() - rd_base), 32'd0);
    check("abort_no_wr", 32'(wa_q.size() - wr_base), 32'd0);
    check("abort_no_done", 32'(done_cnt - done_base), 32'd0);

    // Clean rerun after the abort.
    snap();
    start_frame();
    wait_done("rerun", 300);
    tick();
    check_frame("rerun", '{10, 11, 14, 15, 26, 27, 30, 31});

    // Core emits six results per channel; only the first four are written.
    mode_extra = 1'b1;
    snap();
    start_frame();
    wait_done("extra", 300);
    tick();
    check_frame("extra", '{10, 11, 12, 13, 26, 27, 28, 29});
    mode_extra = 1'b0;

    // start while busy is ignored; Rst during DRAIN clears outputs at once.
    snap();
    start_frame();
    begin
      bit hit = 1'b0;
      for (int i = 0; i < 100; i++) begin
        if (rd_en && rd_addr == AW'(5)) begin
          hit = 1'b1;
          break;
        end
        tick();
      end
      check("busy_reach_feed", 32'(hit), 32'd1);
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    check("busy_start_ignored", {rd_en, conv_clr}, 32'b10);
    check("busy_start_addr", 32'(rd_addr), 32'd6);
    begin
      bit hit = 1'b0;
      for (int i = 0; i < 100; i++) begin
        if (rd_en && rd_addr == AW'(15)) begin
          hit = 1'b1;
          break;
        end
        tick();
      end
      check("busy_reach_last", 32'(hit), 32'd1);
    end
    tick();
    check("drain_state", {busy, rd_en, conv_valid_in}, 32'b101);
    check("drain_pix", 32'(conv_data_in), 32'd15);
    Rst = 1'b1;
    #1;
    check("async_rst_outs", {busy, done, err, rd_en, conv_clr, conv_valid_in, wr_en}, 32'd0);
    check("async_rst_buses", {rd_addr, wr_addr, wr_data}, 32'd0);
    check("async_rst_pix", 32'(conv_data_in), 32'd0);
    tick();
    Rst = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    check("post_rst_idle", {busy, rd_en}, 32'd0);
    check("post_rst_no_done", 32'(done_cnt - done_base), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/conv2d_seq.md
# conv2d_seq

Frame sequencer for the Conv2D3x3 streaming core. On `start` it reads NUM_CH input channels of IMG_SIZE×IMG_SIZE pixels from a synchronous input buffer and streams them into the core with `valid_in`. It collects the core's (IMG_SIZE-2)² valid-convolution outputs per channel into an output buffer, and clears the core's line buffers between channels. It sits between the frame memories and one Conv2D3x3 instance and replaces the file-driven feeding used in unit benches.

## Interface
- IMG_SIZE, 416, input frame width and height in pixels.
- DATA_W, 32, pixel word width.
- NUM_CH, 3, channels processed per `start`.
- ADDR_W, 20, buffer address width; must hold NUM_CH·IMG_SIZE².
- TIMEOUT, 4096, maximum DRAIN cycles before the error abort.

Ports:
- Clk  in  1  clock; all logic is on the rising edge.
- Rst  in  1  asynchronous, active-high reset.
- start  in  1  launch pulse; only sampled in IDLE.
- abort  in  1  synchronous abort; returns to IDLE.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at frame completion.
- err  out  1  sticky timeout flag; cleared on the next accepted `start`.
- rd_en  out  1  input buffer read strobe.
- rd_addr  out  ADDR_W  input buffer address.
- rd_data  in  DATA_W  input buffer data, valid 1 cycle after `rd_en`.
- conv_clr  out  1  one-cycle core line-buffer clear (active-high; inverted at integration).
- conv_data_in  out  DATA_W  pixel to the core.
- conv_valid_in  out  1  pixel valid to the core.
- conv_data_out  in  DATA_W  core result.
- conv_valid_out  in  1  core result valid.
- wr_en  out  1  output buffer write strobe.
- wr_addr  out  ADDR_W  output buffer address.
- wr_data  out  DATA_W  output buffer data.

## Operation
- PIX = IMG_SIZE², OPIX = (IMG_SIZE-2)². Counters: ch (0..NUM_CH-1), rd_ptr (0..PIX-1), wr_ptr (0..OPIX-1), tmo (0..TIMEOUT).
- IDLE: on `start`, clear ch and err, then go to CLEAR.
- CLEAR: `conv_clr`=1 for one cycle; rd_ptr=wr_ptr=0; clear the ch_done flag; go to FEED.
- FEED: `rd_en`=1 every cycle, with rd_addr = ch·PIX + rd_ptr. When rd_ptr == PIX-1, go to DRAIN; otherwise increment rd_ptr.
- DRAIN: increment tmo each cycle. If ch_done is set, go to NEXT. If tmo reaches TIMEOUT, set err and go to DONE.
- NEXT: if ch == NUM_CH-1, go to DONE; otherwise increment ch and go to CLEAR.
- DONE: `done`=1 for one cycle, then go to IDLE.
- Pipeline: conv_valid_in and conv_data_in are `rd_en` and `rd_data` delayed one cycle. This delayed copy is independent of state, so the last pixel issued in FEED still reaches the core in the DRAIN cycle that follows.
- Collect: in FEED or DRAIN with ch_done clear, each `conv_valid_out` registers wr_en=1, wr_addr = ch·OPIX + wr_ptr and wr_data = conv_data_out.
  - The write at wr_ptr == OPIX-1 sets ch_done; otherwise wr_ptr increments.
  - ch_done may set during FEED; DRAIN then exits on its first cycle.
- Ignored outputs: `conv_valid_out` in any other state, or with ch_done set, produces no write.
- `start` while busy is ignored.
- `abort` is high priority: from any state, go to IDLE next cycle. The delayed conv_valid_in and any pending wr_en are cleared, no `done` is issued, and err is unchanged.
- Address arithmetic is unsigned ADDR_W with no wrap; a parameter set that overflows ADDR_W is illegal.

## Timing
- Reset values: state IDLE, all counters 0; busy, done, err, rd_en, conv_clr, conv_valid_in, wr_en all 0; rd_addr, wr_addr, conv_data_in, wr_data all 0.
- Cycle T: `start` sampled in IDLE. T+1: CLEAR (busy=1, conv_clr=1). T+2: first rd_en. T+3: first conv_valid_in.
- FEED lasts exactly PIX cycles per channel, with `rd_en` continuous and no bubbles.
- wr_en follows `conv_valid_out` by 1 cycle.
- Per-channel overhead is CLEAR 1 + NEXT 1 + DRAIN (≥1) cycles.
- `done` goes high the cycle after the last NEXT; busy drops the cycle after `done`.
- Core latency only affects DRAIN length; DRAIN is bounded by TIMEOUT.

## Test plan
All scenarios use IMG_SIZE=4 (PIX=16, OPIX=4), NUM_CH=2, a behavioural core with fixed latency L=5, and an input buffer preloaded with word value = address.
- Single `start` -> input reads at addresses 0–15 then 16–31; 4 writes at addresses 0–3 and 4–7; 2 conv_clr pulses; `done` once; err=0.
- Check pixel and clear timing -> conv_data_in sequence equals 0..15 with conv_valid_in one cycle after each rd_en; no conv_valid_in during CLEAR.
- Core never asserts `conv_valid_out` -> after TIMEOUT DRAIN cycles: err=1, `done` pulse, no channel-1 reads.
- `abort` at the 8th FEED cycle of ch 1 -> IDLE next cycle; busy=0; no `done`; no further rd_en or wr_en. A subsequent `start` reruns cleanly from address 0.
- Core emits 6 results for ch 0 -> only the first 4 are written; the extra 2 cause no wr_en and no address overrun.
- `start` pulsed while busy, and `Rst` asserted during DRAIN -> mid-frame `start` has no effect; `Rst` immediately returns all outputs to their reset values.
